// File: rtl/cpu_sram_arbiter.sv
// Two-channel (instruction / data) SRAM-like request arbiter onto one shared
// memory port. One transaction outstanding at a time, round-robin on ties,
// responses routed back only to the channel that issued the request.
module cpu_sram_arbiter (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        grant_inst;
    logic        grant_data;
    logic        owner;        // 0 = inst, 1 = data
    logic        last_grant;   // 0 = inst, 1 = data
    logic        wr_r;
    logic [3:0]  wstrb_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        inst_ok_r;
    logic        data_ok_r;

    // Grant selection in IDLE and next-state logic for the transaction FSM
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (inst_req && data_req) begin
                    // Tie: whoever did not win last time goes now
                    if (last_grant) grant_inst = 1'b1;
                    else            grant_data = 1'b1;
                end else if (inst_req) begin
                    grant_inst = 1'b1;
                end else if (data_req) begin
                    grant_data = 1'b1;
                end
                if (grant_inst || grant_data) state_next = REQ;
            end
            REQ:     if (mem_req_ready)  state_next = RESP;
            RESP:    if (mem_resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign inst_addr_ok  = grant_inst;
    assign data_addr_ok  = grant_data;
    assign mem_req_valid = (state == REQ);
    assign mem_wr        = wr_r;
    assign mem_wstrb     = wstrb_r;
    assign mem_addr      = addr_r;
    assign mem_wdata     = wdata_r;
    assign inst_data_ok  = inst_ok_r;
    assign data_data_ok  = data_ok_r;
    assign inst_rdata    = rdata_r;
    assign data_rdata    = rdata_r;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Capture the granted channel's request fields and ownership
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner      <= 1'b0;
            last_grant <= 1'b0;
            wr_r       <= 1'b0;
            wstrb_r    <= 4'h0;
            addr_r     <= 32'h0;
            wdata_r    <= 32'h0;
        end else if (grant_data) begin
            owner      <= 1'b1;
            last_grant <= 1'b1;
            wr_r       <= data_wr;
            wstrb_r    <= data_wstrb;
            addr_r     <= data_addr;
            wdata_r    <= data_wdata;
        end else if (grant_inst) begin
            owner      <= 1'b0;
            last_grant <= 1'b0;
            wr_r       <= inst_wr;
            wstrb_r    <= inst_wstrb;
            addr_r     <= inst_addr;
            wdata_r    <= inst_wdata;
        end
    end

    // Register the response and pulse the owner's completion for one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_r   <= 32'h0;
            inst_ok_r <= 1'b0;
            data_ok_r <= 1'b0;
        end else begin
            inst_ok_r <= 1'b0;
            data_ok_r <= 1'b0;
            if (state == RESP && mem_resp_valid) begin
                rdata_r   <= mem_rdata;
                inst_ok_r <= ~owner;
                data_ok_r <= owner;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed testbench for cpu_sram_arbiter: reset state, single read,
// contention, backpressure, spurious responses, mid-transaction reset and
// back-to-back throughput.
module tb_cpu_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wr, mem_resp_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cpu_sram_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later
    task automatic nxt;
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;

        // ---------------- reset state ----------------
        nxt; nxt; #1;
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 0);
        chk("rst_inst_data_ok",  {31'b0, inst_data_ok}, 0);
        chk("rst_data_data_ok",  {31'b0, data_data_ok}, 0);
        chk("rst_inst_addr_ok",  {31'b0, inst_addr_ok}, 0);
        chk("rst_data_addr_ok",  {31'b0, data_addr_ok}, 0);
        chk("rst_rdata",         inst_rdata, 0);
        chk("rst_mem_addr",      mem_addr, 0);
        chk("rst_mem_fields",    {27'b0, mem_wr, mem_wstrb}, 0);
        chk("rst_mem_wdata",     mem_wdata, 0);
        nxt; resetn = 1'b1;

        // ---------------- single read ----------------
        nxt; data_req = 1; data_addr = 32'h1c000100; mem_req_ready = 1; #1;
        chk("rd_t0_data_addr_ok", {31'b0, data_addr_ok}, 1);
        chk("rd_t0_inst_addr_ok", {31'b0, inst_addr_ok}, 0);
        chk("rd_t0_valid",        {31'b0, mem_req_valid}, 0);
        nxt; data_req = 0; #1;
        chk("rd_t1_valid",        {31'b0, mem_req_valid}, 1);
        chk("rd_t1_addr",         mem_addr, 32'h1c000100);
        chk("rd_t1_wr",           {31'b0, mem_wr}, 0);
        nxt; mem_resp_valid = 1; mem_rdata = 32'hDEADBEEF; #1;
        chk("rd_t2_valid",        {31'b0, mem_req_valid}, 0);
        chk("rd_t2_data_ok",      {31'b0, data_data_ok}, 0);
        nxt; mem_resp_valid = 0; #1;
        chk("rd_t3_data_ok",      {31'b0, data_data_ok}, 1);
        chk("rd_t3_rdata",        data_rdata, 32'hDEADBEEF);
        chk("rd_t3_inst_ok",      {31'b0, inst_data_ok}, 0);
        nxt; #1;
        chk("rd_t4_data_ok",      {31'b0, data_data_ok}, 0);

        // ---------------- contention (fresh reset: data wins first tie) ----------------
        resetn = 0; #1; nxt; resetn = 1;
        for (int k = 0; k < 5; k++) begin
            nxt; inst_req = (k < 4); data_req = (k < 4); mem_resp_valid = 0; #1;
            chk($sformatf("ct%0d_data_addr_ok", k), {31'b0, data_addr_ok}, (k < 4) && (k % 2 == 0));
            chk($sformatf("ct%0d_inst_addr_ok", k), {31'b0, inst_addr_ok}, (k < 4) && (k % 2 == 1));
            if (k > 0) begin
                chk($sformatf("ct%0d_data_ok", k), {31'b0, data_data_ok}, ((k - 1) % 2 == 0));
                chk($sformatf("ct%0d_inst_ok", k), {31'b0, inst_data_ok}, ((k - 1) % 2 == 1));
                chk($sformatf("ct%0d_rdata", k), data_rdata, 32'h100 + k - 1);
            end
            if (k < 4) begin
                nxt; #1;
                chk($sformatf("ct%0d_req_addr_ok", k), {30'b0, inst_addr_ok, data_addr_ok}, 0);
                chk($sformatf("ct%0d_req_valid", k), {31'b0, mem_req_valid}, 1);
                nxt; mem_resp_valid = 1; mem_rdata = 32'h100 + k; #1;
                chk($sformatf("ct%0d_resp_addr_ok", k), {30'b0, inst_addr_ok, data_addr_ok}, 0);
            end
        end

        // ---------------- backpressure on a write ----------------
        nxt; data_req = 1; data_wr = 1; data_addr = 32'h8; data_wstrb = 4'h3;
        data_wdata = 32'h12345678; mem_req_ready = 0; #1;
        chk("bp_t0_addr_ok", {31'b0, data_addr_ok}, 1);
        for (int t = 1; t <= 4; t++) begin
            nxt; data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
            mem_req_ready = (t == 4); #1;
            chk($sformatf("bp_t%0d_valid", t), {31'b0, mem_req_valid}, 1);
            chk($sformatf("bp_t%0d_addr", t),  mem_addr, 32'h8);
            chk($sformatf("bp_t%0d_wr_wstrb", t), {27'b0, mem_wr, mem_wstrb}, {27'b0, 1'b1, 4'h3});
            chk($sformatf("bp_t%0d_wdata", t), mem_wdata, 32'h12345678);
        end
        nxt; mem_req_ready = 0; #1;
        chk("bp_t5_valid", {31'b0, mem_req_valid}, 0);
        nxt; mem_resp_valid = 1; mem_rdata = 32'h0; #1;
        chk("bp_t6_data_ok", {31'b0, data_data_ok}, 0);
        nxt; mem_resp_valid = 0; #1;
        chk("bp_t7_data_ok", {31'b0, data_data_ok}, 1);
        chk("bp_t7_inst_ok", {31'b0, inst_data_ok}, 0);
        chk("bp_t7_addr_hold", mem_addr, 32'h8);

        // ---------------- spurious responses in IDLE and REQ ----------------
        nxt; mem_resp_valid = 1; mem_rdata = 32'h5555AAAA; #1;
        nxt; mem_resp_valid = 0; #1;
        chk("sp_idle_oks", {30'b0, inst_data_ok, data_data_ok}, 0);
        chk("sp_idle_valid", {31'b0, mem_req_valid}, 0);
        inst_req = 1; inst_wr = 1; inst_wstrb = 4'hF; inst_addr = 32'h40; inst_wdata = 32'hCAFE0001; #1;
        chk("sp_inst_addr_ok", {31'b0, inst_addr_ok}, 1);
        nxt; inst_req = 0; inst_wr = 0; mem_resp_valid = 1; #1;
        chk("sp_req_valid", {31'b0, mem_req_valid}, 1);
        chk("sp_inst_wr_fwd", {31'b0, mem_wr}, 1);
        nxt; mem_resp_valid = 0; #1;
        chk("sp_req_still_valid", {31'b0, mem_req_valid}, 1);
        chk("sp_req_oks", {30'b0, inst_data_ok, data_data_ok}, 0);
        mem_req_ready = 1;
        nxt; mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0BADF00D; #1;
        nxt; mem_resp_valid = 0; #1;
        chk("sp_inst_ok", {31'b0, inst_data_ok}, 1);
        chk("sp_data_ok", {31'b0, data_data_ok}, 0);

        // ---------------- reset mid-transaction ----------------
        nxt; inst_req = 1; inst_addr = 32'h1000; mem_req_ready = 1; #1;
        chk("mr_addr_ok", {31'b0, inst_addr_ok}, 1);
        nxt; inst_req = 0; #1;
        nxt; resetn = 0; #1;
        chk("mr_valid_in_reset", {31'b0, mem_req_valid}, 0);
        chk("mr_addr_cleared", mem_addr, 0);
        nxt; resetn = 1; mem_resp_valid = 1; mem_rdata = 32'h77777777; #1;
        nxt; mem_resp_valid = 0; #1;
        chk("mr_late_oks", {30'b0, inst_data_ok, data_data_ok}, 0);
        chk("mr_late_valid", {31'b0, mem_req_valid}, 0);

        // ---------------- back-to-back (first grant is the post-reset request) ----------------
        for (int k = 0; k < 4; k++) begin
            inst_req = (k < 3); inst_addr = 32'h2000 + 4 * k; mem_resp_valid = 0; #1;
            chk($sformatf("bb%0d_addr_ok", k), {31'b0, inst_addr_ok}, (k < 3));
            if (k > 0) begin
                chk($sformatf("bb%0d_inst_ok", k), {31'b0, inst_data_ok}, 1);
                chk($sformatf("bb%0d_rdata", k), inst_rdata, 32'hA0 + k - 1);
            end
            if (k < 3) begin
                nxt; #1;
                chk($sformatf("bb%0d_valid", k), {31'b0, mem_req_valid}, 1);
                chk($sformatf("bb%0d_addr", k), mem_addr, 32'h2000 + 4 * k);
                nxt; mem_resp_valid = 1; mem_rdata = 32'hA0 + k; #1;
                chk($sformatf("bb%0d_resp_addr_ok", k), {31'b0, inst_addr_ok}, 0);
                nxt;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_sram_arbiter.md
# cpu_sram_arbiter

Merges the two SRAM-like request channels of the CPU core (instruction fetch and data load/store) onto one shared memory port with a valid/ready request handshake and a response strobe. It sits directly downstream of the CPU top level. It keeps exactly one transaction outstanding, grants round-robin on contention, and returns each response only to the channel that issued it.

## Interface
Parameters: none.

Ports. Paired lines list the inst_* and data_* copies, one port per channel.
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req / data_req  in  1  channel request, held until matching addr_ok
- inst_wr / data_wr  in  1  1 = write, 0 = read
- inst_wstrb / data_wstrb  in  4  byte enables for writes
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle (combinational)
- inst_data_ok / data_data_ok  out  1  one-cycle registered completion pulse
- inst_rdata / data_rdata  out  32  read data, valid only while the own data_ok is high
- mem_req_valid  out  1  request valid toward memory
- mem_req_ready  in  1  memory accepts request
- mem_wr  out  1  latched write flag
- mem_wstrb  out  4  latched byte enables
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched write data
- mem_resp_valid  in  1  response strobe; always accepted in RESP
- mem_rdata  in  32  response data

## Operation
- States: IDLE, REQ, RESP.
- Internal registers:
  - owner (0 = inst, 1 = data)
  - last_grant
  - latched wr/wstrb/addr/wdata
  - rdata_r, inst_ok_r, data_ok_r
- IDLE, grant rules:
  - Only data_req: grant data.
  - Only inst_req: grant inst.
  - Both: grant inst if last_grant = data, else grant data.
- IDLE, on a grant:
  - The granted channel's addr_ok = 1 in the same cycle. The other channel's addr_ok = 0.
  - Latch the granted fields, set owner and last_grant, go to REQ.
- addr_ok is 0 in REQ and RESP. A requester holds its request.
- REQ: mem_req_valid = 1, driven from the latched fields. On mem_req_ready go to RESP.
- mem_* fields are stable while mem_req_valid = 1.
- mem_wr/wstrb/addr/wdata hold their last latched value outside REQ. Only mem_req_valid qualifies them.
- RESP: on mem_resp_valid:
  - rdata_r <= mem_rdata.
  - owner's ok_r <= 1 for one cycle.
  - Go to IDLE.
- Writes also complete through mem_resp_valid. data_ok pulses and rdata content is don't-care.
- inst_rdata = data_rdata = rdata_r. Each is qualified only by its own data_ok.
- mem_resp_valid in IDLE or REQ is ignored: no state change, no data_ok.
- inst_wr = 1 is forwarded unchanged. The arbiter does not filter it.

## Timing
- Reset (asynchronous, on resetn low):
  - State IDLE.
  - last_grant = inst, so data wins the first tie.
  - Outputs after reset: mem_req_valid = 0, both data_ok = 0, both addr_ok = 0 (with req low), rdata_r = 0, latched fields = 0.
- Reset mid-transaction aborts it. No data_ok is produced for it, and any late response is ignored.
- Cycle sequence, with t0 = addr_ok cycle:
  - t0: addr_ok.
  - t1: mem_req_valid first high.
  - t2: earliest mem_resp_valid, if ready at t1.
  - t3: data_ok.
- Minimum addr_ok-to-data_ok latency is 3 cycles. Each mem_req_ready wait cycle adds 1; each response wait cycle adds 1.
- Memory never asserts mem_resp_valid in the cycle of the request handshake.
- The data_ok pulse cycle is spent in IDLE, so a new addr_ok may coincide with the previous data_ok. Back-to-back throughput is one transaction per 3 cycles.
- Never more than one transaction outstanding. The two data_ok outputs are never high together.

## Test plan
- Single read: after reset, data_req with addr 0x1c000100, mem_req_ready tied 1, response 0xDEADBEEF one cycle after handshake:
  - data_addr_ok at t0, mem_req_valid at t1, data_data_ok at t3 with data_rdata = 0xDEADBEEF.
  - inst_data_ok stays 0.
- Contention: inst_req and data_req held continuously from reset:
  - Grants alternate data, inst, data, inst.
  - Each data_ok goes to the granted channel.
  - No addr_ok while in REQ/RESP.
- Backpressure: mem_req_ready low for 4 cycles on a write (addr 0x8, wstrb 0x3, wdata 0x12345678):
  - mem_* fields are constant during the 4 cycles.
  - data_data_ok arrives 7 cycles after addr_ok, with 1 response wait.
- Spurious response: mem_resp_valid pulsed in IDLE and in REQ → no data_ok, no state change.
- Reset mid-operation: resetn low during RESP, then the response arrives after release → no data_ok, mem_req_valid = 0, the next inst_req is accepted normally.
- Back-to-back: inst_req held with continuous immediate responses → inst_addr_ok every 3 cycles, each coinciding with the previous inst_data_ok.
